// File: rtl/seq_pattern_detector.sv
// ---------------------------------------------------------------------------
// seq_pattern_detector
//   Serial bit-pattern detector. One bit of din is taken on every clock with
//   en=1. The newest PAT_LEN bits are compared against PATTERN. The MSB of
//   PATTERN is the oldest bit received. A hit happens when the incoming bit
//   completes the pattern.
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst        in   1      synchronous reset, active high, overrides all
//   en         in   1      bit-valid strobe; din sampled only when en=1
//   din        in   1      serial data bit
//   clr        in   1      synchronous clear of det_flag / match_cnt
//   match      out  1      registered one-cycle pulse per hit
//   det_flag   out  1      sticky "seen at least one match"
//   match_cnt  out  CNT_W  saturating match count since rst/clr
// ---------------------------------------------------------------------------
module seq_pattern_detector #(
    parameter int unsigned         PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0]  PATTERN = 4'b1010,
    parameter bit                  OVERLAP = 1'b1,
    parameter int unsigned         CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic             clr,
    output logic             match,
    output logic             det_flag,
    output logic [CNT_W-1:0] match_cnt
);

    generate
        if (PAT_LEN < 1 || PAT_LEN > 16) begin : g_bad_len
            $error("seq_pattern_detector: PAT_LEN must be 1..16");
        end
        if (CNT_W < 1) begin : g_bad_cnt
            $error("seq_pattern_detector: CNT_W must be >= 1");
        end
    endgenerate

    localparam int unsigned        FILL_W   = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(PAT_LEN);
    localparam logic [FILL_W-1:0]  FILL_ARM = FILL_W'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    logic [PAT_LEN-1:0] window;
    logic [FILL_W-1:0]  fill;
    logic [PAT_LEN-1:0] next_win;
    logic               hit;

    // The window as it would look with din shifted in. For a 1-bit pattern
    // this is just din itself.
    generate
        if (PAT_LEN == 1) begin : g_len1
            assign next_win = din;
        end else begin : g_lenn
            assign next_win = {window[PAT_LEN-2:0], din};
        end
    endgenerate

    // Valid when at least PAT_LEN-1 older bits are held, so the incoming
    // bit is the one that completes the pattern.
    assign hit = en && (fill >= FILL_ARM) && (next_win == PATTERN);

    always_ff @(posedge clk) begin
        if (rst) begin
            window    <= '0;
            fill      <= '0;
            match     <= 1'b0;
            det_flag  <= 1'b0;
            match_cnt <= '0;
        end else begin
            match <= hit;

            if (en) begin
                if (hit && !OVERLAP) begin
                    // Non-overlapping: the next match needs PAT_LEN fresh bits.
                    window <= '0;
                    fill   <= '0;
                end else begin
                    window <= next_win;
                    if (fill != FILL_MAX)
                        fill <= fill + 1'b1;
                end
            end

            // A hit wins over a clr in the same cycle.
            if (hit)
                det_flag <= 1'b1;
            else if (clr)
                det_flag <= 1'b0;

            // clr restarts the count. A hit in the same cycle counts as the
            // first match of the new count.
            if (clr)
                match_cnt <= hit ? CNT_ONE : '0;
            else if (hit && match_cnt != CNT_MAX)
                match_cnt <= match_cnt + 1'b1;
        end
    end

endmodule
